// File: rtl/ftdi_245_tx_pkg.sv
// Shared types for the FTDI sync-245 transmit engine: FSM encoding and burst counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ftdi_245_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TURN    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RELEASE = 2'd3
    } tx_state_t;

    // Bits needed to hold a burst count from 0 up to and including max_burst.
    function automatic int burst_cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/ftdi_245_tx_if.sv
// Stream, chip-pin and arbiter signals of the FTDI sync-245 transmit engine.
// Latency: n/a (wiring only).
// Backpressure: i_rdy throttles the stream; usb_txe_n and bus_gnt throttle the engine.
interface ftdi_245_tx_if #(
    parameter int DW = 8
);
    logic          i_rdy;
    logic          i_en;
    logic [DW-1:0] i_data;
    logic          usb_txe_n;
    logic          usb_wr_n;
    logic [DW-1:0] usb_data_out;
    logic          usb_data_oe;
    logic          bus_req;
    logic          bus_gnt;

    // Engine side.
    modport master (
        output i_rdy,
        input  i_en,
        input  i_data,
        input  usb_txe_n,
        output usb_wr_n,
        output usb_data_out,
        output usb_data_oe,
        output bus_req,
        input  bus_gnt
    );

    // Stream source, chip and arbiter side.
    modport slave (
        input  i_rdy,
        output i_en,
        output i_data,
        output usb_txe_n,
        input  usb_wr_n,
        input  usb_data_out,
        input  usb_data_oe,
        input  bus_req,
        output bus_gnt
    );
endinterface

// File: rtl/ftdi_tx_skid2.sv
// Two-entry hold/stage buffer: H feeds the chip data pins, S catches the next byte.
// Latency: a pushed byte is visible in H after one edge when H is free, else it waits in S.
// Backpressure: rdy is a register equal to "S empty after this edge"; low during reset.
module ftdi_tx_skid2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          consume,
    output logic          rdy,
    output logic [DW-1:0] h_dat,
    output logic          h_vld_nxt
);

    logic          h_vld_q, h_vld_d;
    logic [DW-1:0] h_dat_q, h_dat_d;
    logic          s_vld_q, s_vld_d;
    logic [DW-1:0] s_dat_q, s_dat_d;
    logic          rdy_q;

    // Next buffer contents: S always drains into H before a new byte may land in H.
    always_comb begin
        h_vld_d = h_vld_q;
        h_dat_d = h_dat_q;
        s_vld_d = s_vld_q;
        s_dat_d = s_dat_q;
        if (!h_vld_q || consume) begin
            if (s_vld_q) begin
                h_vld_d = 1'b1;
                h_dat_d = s_dat_q;
                s_vld_d = push;
                if (push) begin
                    s_dat_d = push_data;
                end
            end else begin
                h_vld_d = push;
                if (push) begin
                    h_dat_d = push_data;
                end
            end
        end else if (push) begin
            s_vld_d = 1'b1;
            s_dat_d = push_data;
        end
    end

    // Buffer registers; reset discards everything and zeroes the pin-facing H data.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            h_vld_q <= 1'b0;
            h_dat_q <= '0;
            s_vld_q <= 1'b0;
            s_dat_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            h_vld_q <= h_vld_d;
            h_dat_q <= h_dat_d;
            s_vld_q <= s_vld_d;
            s_dat_q <= s_dat_d;
            rdy_q   <= !s_vld_d;
        end
    end

    assign rdy       = rdy_q;
    assign h_dat     = h_dat_q;
    assign h_vld_nxt = h_vld_d;

endmodule

// File: rtl/ftdi_245_tx.sv
// FTDI sync-245 transmit engine: arbitrates for the shared data bus and strobes stream bytes to the chip.
// Latency: byte accepted in IDLE with grant high is driven with wr_n low two edges later (TURN, WRITE).
// Backpressure: usb_txe_n high holds the byte on the pins; a full stage register drops i_rdy.
// Optional build macro FTDI_TX_BYTE_CNT_EN adds a 32-bit wrapping count of chip-consumed bytes.
module ftdi_245_tx
    import ftdi_245_tx_pkg::*;
#(
    parameter int DW        = 8,
    parameter int MAX_BURST = 64
) (
    input  logic         clk,
    input  logic         rstn,
    ftdi_245_tx_if.master bus
`ifdef FTDI_TX_BYTE_CNT_EN
    ,
    output logic [31:0]  tx_byte_cnt
`endif
);

    localparam int             BCW      = burst_cnt_w(MAX_BURST);
    localparam logic [BCW-1:0] LAST_IDX = BCW'(MAX_BURST - 1);

    tx_state_t      state_q, state_d;
    logic [BCW-1:0] burst_q, burst_d;
    logic           wr_n_q, wr_n_d;
    logic           oe_q, oe_d;
    logic           req_q, req_d;

    logic           in_rdy;
    logic           push;
    logic           consume;
    logic           last_byte;
    logic           h_vld_nxt;
    logic [DW-1:0]  h_dat;

    // The chip takes the byte on H at any edge where both strobes are low.
    assign push      = bus.i_en & in_rdy;
    assign consume   = ~wr_n_q & ~bus.usb_txe_n;
    assign last_byte = consume & (burst_q == LAST_IDX);

    ftdi_tx_skid2 #(
        .DW (DW)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (bus.i_data),
        .consume   (consume),
        .rdy       (in_rdy),
        .h_dat     (h_dat),
        .h_vld_nxt (h_vld_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a tenure ends when data runs dry, the grant is lost or the burst limit is hit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_q && bus.bus_gnt) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (!h_vld_nxt || !bus.bus_gnt || last_byte) begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin values for the next cycle, derived from the state being entered.
    always_comb begin
        oe_d   = (state_d != ST_IDLE);
        wr_n_d = !((state_d == ST_WRITE) && h_vld_nxt);
        req_d  = (state_d == ST_TURN) || (state_d == ST_WRITE) ||
                 ((state_d == ST_IDLE) && h_vld_nxt);
        if (state_d == ST_IDLE) begin
            burst_d = '0;
        end else if (consume) begin
            burst_d = burst_q + BCW'(1);
        end else begin
            burst_d = burst_q;
        end
    end

    // Pin and burst-counter registers; reset releases the bus at once.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            req_q   <= 1'b0;
            burst_q <= '0;
        end else begin
            wr_n_q  <= wr_n_d;
            oe_q    <= oe_d;
            req_q   <= req_d;
            burst_q <= burst_d;
        end
    end

    assign bus.i_rdy        = in_rdy;
    assign bus.usb_wr_n     = wr_n_q;
    assign bus.usb_data_oe  = oe_q;
    assign bus.bus_req      = req_q;
    assign bus.usb_data_out = h_dat;

`ifdef FTDI_TX_BYTE_CNT_EN
    logic [31:0] byte_cnt_q;

    // Running count of bytes the chip has taken; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            byte_cnt_q <= '0;
        end else if (consume) begin
            byte_cnt_q <= byte_cnt_q + 32'd1;
        end
    end

    assign tx_byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_ftdi_245_tx.sv
// Bench for ftdi_245_tx: table of burst scenarios, hand-written corner sequences, random traffic.
// Reference: a FIFO of accepted stream bytes that every chip write must match in order.
module tb_ftdi_245_tx;

    localparam int DW = 8;
    localparam int MB = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ftdi_245_tx_if #(.DW(DW)) bus_if ();

`ifdef FTDI_TX_BYTE_CNT_EN
    logic [31:0] tx_byte_cnt;
`endif

    ftdi_245_tx #(
        .DW        (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
`ifdef FTDI_TX_BYTE_CNT_EN
        ,
        .tx_byte_cnt (tx_byte_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: bytes accepted from the stream but not yet taken by the chip.
    logic [7:0] exp_q[$];
    int  writes    = 0;
    int  pushes    = 0;
    int  tenures   = 0;
    int  wr_low    = 0;
    int  burst_len = 0;
    logic oe_prev  = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            burst_len = 0;
            oe_prev   = 1'b0;
        end else begin
            if (bus_if.usb_data_oe && !oe_prev) begin
                tenures++;
                burst_len = 0;
            end
            oe_prev = bus_if.usb_data_oe;
            if (!bus_if.usb_wr_n) begin
                wr_low++;
                chk("oe_high_while_wr", int'(bus_if.usb_data_oe), 1);
                if (!bus_if.usb_txe_n) begin
                    writes++;
                    burst_len++;
                    chk("write_has_pending_byte", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        chk("write_data", int'(bus_if.usb_data_out), int'(exp_q.pop_front()));
                    end
                    chk("burst_within_limit", int'(burst_len <= MB), 1);
                end
            end
            if (bus_if.i_en && bus_if.i_rdy) begin
                exp_q.push_back(bus_if.i_data);
                pushes++;
            end
        end
    end

    task automatic push_bytes(input int n, input logic [7:0] base);
        int   k     = 0;
        int   guard = 0;
        logic sent;
        while (k < n && guard < 2000) begin
            bus_if.i_en   = 1'b1;
            bus_if.i_data = base + 8'(k);
            @(negedge clk);
            sent = bus_if.i_rdy;
            @(posedge clk);
            #1;
            if (sent) k++;
            guard++;
        end
        bus_if.i_en = 1'b0;
        chk("push_done", k, n);
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || bus_if.usb_data_oe || bus_if.bus_req) && g < 3000) begin
            tick(1);
            g++;
        end
        chk(name, int'(g < 3000), 1);
    endtask

    typedef struct {
        int         nbytes;
        logic [7:0] base;
        int         exp_writes;
        int         exp_tenures;
        int         exp_wrlow;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, t0, l0, p0, g;
        logic [7:0] held;

        vecs[0] = '{1,  8'hA5, 1,  1, 1};
        vecs[1] = '{4,  8'h10, 4,  1, 4};
        vecs[2] = '{5,  8'h20, 5,  2, 5};
        vecs[3] = '{10, 8'h30, 10, 3, 10};
        vecs[4] = '{8,  8'h40, 8,  2, 8};

        bus_if.i_en      = 1'b0;
        bus_if.i_data    = '0;
        bus_if.usb_txe_n = 1'b1;
        bus_if.bus_gnt   = 1'b0;

        // Reset values.
        tick(3);
        chk("rst_i_rdy", int'(bus_if.i_rdy), 0);
        chk("rst_wr_n", int'(bus_if.usb_wr_n), 1);
        chk("rst_data", int'(bus_if.usb_data_out), 0);
        chk("rst_oe", int'(bus_if.usb_data_oe), 0);
        chk("rst_req", int'(bus_if.bus_req), 0);
        rstn = 1'b1;
        tick(1);
        chk("post_rst_i_rdy", int'(bus_if.i_rdy), 1);

        // Single byte, cycle by cycle: IDLE(req) -> TURN -> WRITE -> RELEASE -> IDLE.
        bus_if.bus_gnt   = 1'b1;
        bus_if.usb_txe_n = 1'b0;
        bus_if.i_en      = 1'b1;
        bus_if.i_data    = 8'hA5;
        tick(1);
        bus_if.i_en = 1'b0;
        chk("single_req", int'(bus_if.bus_req), 1);
        chk("single_idle_oe", int'(bus_if.usb_data_oe), 0);
        tick(1);
        chk("single_turn_oe", int'(bus_if.usb_data_oe), 1);
        chk("single_turn_wr_n", int'(bus_if.usb_wr_n), 1);
        tick(1);
        chk("single_write_wr_n", int'(bus_if.usb_wr_n), 0);
        chk("single_write_data", int'(bus_if.usb_data_out), 8'hA5);
        tick(1);
        chk("single_release_wr_n", int'(bus_if.usb_wr_n), 1);
        chk("single_release_oe", int'(bus_if.usb_data_oe), 1);
        chk("single_release_req", int'(bus_if.bus_req), 0);
        tick(1);
        chk("single_idle_after_oe", int'(bus_if.usb_data_oe), 0);

        // Table: continuous streams with grant held; bursts split at MB bytes.
        for (int i = 0; i < 5; i++) begin
            w0 = writes; t0 = tenures; l0 = wr_low;
            push_bytes(vecs[i].nbytes, vecs[i].base);
            wait_idle("vec_idle");
            chk("vec_writes", writes - w0, vecs[i].exp_writes);
            chk("vec_tenures", tenures - t0, vecs[i].exp_tenures);
            chk("vec_wr_low_cycles", wr_low - l0, vecs[i].exp_wrlow);
        end

        // Burst of 16 with txe_n high during WRITE cycles 4..6.
        w0 = writes; t0 = tenures;
        fork
            push_bytes(16, 8'h00);
            begin
                int gs = 0;
                while (bus_if.usb_wr_n && gs < 200) begin
                    tick(1);
                    gs++;
                end
                chk("stall_reached_write", int'(gs < 200), 1);
                tick(3);
                bus_if.usb_txe_n = 1'b1;
                held = bus_if.usb_data_out;
                for (int j = 0; j < 3; j++) begin
                    tick(1);
                    chk("stall_data_held", int'(bus_if.usb_data_out), int'(held));
                    chk("stall_wr_n_low", int'(bus_if.usb_wr_n), 0);
                    if (j < 2) chk("stall_i_rdy_low", int'(bus_if.i_rdy), 0);
                end
                bus_if.usb_txe_n = 1'b0;
            end
        join
        wait_idle("stall_idle");
        chk("stall_writes", writes - w0, 16);
        chk("stall_tenures", tenures - t0, 4);

        // Preemption: grant drops while the 3rd byte is being written.
        w0 = writes; t0 = tenures;
        fork
            push_bytes(6, 8'h60);
            begin
                int gp = 0;
                while (!((writes - w0) == 2 && !bus_if.usb_wr_n) && gp < 200) begin
                    tick(1);
                    gp++;
                end
                chk("preempt_reached", int'(gp < 200), 1);
                bus_if.bus_gnt = 1'b0;
                tick(1);
                chk("preempt_three_written", writes - w0, 3);
                chk("preempt_release_wr_n", int'(bus_if.usb_wr_n), 1);
                chk("preempt_release_req", int'(bus_if.bus_req), 0);
                chk("preempt_release_oe", int'(bus_if.usb_data_oe), 1);
                tick(3);
                chk("preempt_idle_oe", int'(bus_if.usb_data_oe), 0);
                chk("preempt_rerequest", int'(bus_if.bus_req), 1);
                chk("preempt_no_write_ungranted", writes - w0, 3);
                bus_if.bus_gnt = 1'b1;
            end
        join
        wait_idle("preempt_idle");
        chk("preempt_writes", writes - w0, 6);
        chk("preempt_tenures", tenures - t0, 2);

        // Reset in WRITE with H and S both full (chip not ready).
        bus_if.usb_txe_n = 1'b1;
        bus_if.i_en      = 1'b1;
        bus_if.i_data    = 8'hC3;
        g = 0;
        while (!(!bus_if.usb_wr_n && !bus_if.i_rdy) && g < 200) begin
            tick(1);
            g++;
        end
        chk("rstmid_reached_full", int'(g < 200), 1);
        rstn        = 1'b0;
        bus_if.i_en = 1'b0;
        tick(1);
        chk("rstmid_wr_n", int'(bus_if.usb_wr_n), 1);
        chk("rstmid_oe", int'(bus_if.usb_data_oe), 0);
        chk("rstmid_req", int'(bus_if.bus_req), 0);
        w0 = writes;
        rstn             = 1'b1;
        bus_if.usb_txe_n = 1'b0;
        tick(1);
        chk("rstmid_i_rdy", int'(bus_if.i_rdy), 1);
        tick(10);
        chk("rstmid_nothing_written", writes - w0, 0);
        chk("rstmid_idle_oe", int'(bus_if.usb_data_oe), 0);
        chk("rstmid_idle_req", int'(bus_if.bus_req), 0);

        // Random traffic against the reference FIFO.
        w0 = writes; p0 = pushes;
        for (int c = 0; c < 3000; c++) begin
            bus_if.i_en      = ($urandom_range(0, 99) < 70);
            bus_if.i_data    = 8'($urandom);
            bus_if.usb_txe_n = ($urandom_range(0, 99) < 25);
            bus_if.bus_gnt   = ($urandom_range(0, 99) < 85);
            tick(1);
        end
        bus_if.i_en      = 1'b0;
        bus_if.usb_txe_n = 1'b0;
        bus_if.bus_gnt   = 1'b1;
        wait_idle("rand_drain");
        chk("rand_all_written", writes - w0, pushes - p0);
        chk("rand_some_traffic", int'((pushes - p0) > 100), 1);

`ifdef FTDI_TX_BYTE_CNT_EN
        // Byte counter wrap from 2^32-2 after three writes.
        force dut.byte_cnt_q = 32'hFFFF_FFFE;
        tick(1);
        release dut.byte_cnt_q;
        push_bytes(3, 8'h90);
        wait_idle("cnt_idle");
        chk("byte_cnt_wrap", int'(tx_byte_cnt), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
